fifo_stress_test: RTL
=====================

# fifo_stress_test

Single-clock, parametrised stress harness for any FIFO with a req/flag interface. It generates a deterministic data pattern and pushes it into the FIFO under test, paced per side by a selectable throttle. It checks every word read back against a locally regenerated expected stream, honouring a configurable read latency. It reports sticky and counted errors, captures the first mismatch, and optionally cross-checks the FIFO's full/empty flags against an occupancy model.

## Interface
- DAT_WIDTH, 16: data width of the FIFO under test (8..32).
- DEPTH, 32: word capacity of the FIFO under test; sizes the occupancy model.
- RD_LATENCY, 1: cycles from `rd_req` to valid `rd_dat` (0 = showahead, 1..4 = registered).
- PATTERN, 0: 0 = counter, p(n) = n mod 2^DAT_WIDTH; 1 = maximal-length LFSR, seed 1.
- CNT_WIDTH, 16: width of the read counter and the error counter.
- FLAG_CHECK, 1: enables the full/empty consistency check.

Ports:
- clk  in  1  single clock for harness and FIFO under test.
- sclr  in  1  synchronous active-high reset; the FIFO under test must receive the same reset.
- wr_mode  in  2  write pacing: 00 off, 01 continuous, 10 random ~50%, 11 random ~25%.
- rd_mode  in  2  read pacing, same encoding.
- wr_dat  out  DAT_WIDTH  pattern word to the FIFO.
- wr_req  out  1  write strobe.
- wr_full  in  1  FIFO full flag.
- rd_req  out  1  read strobe.
- rd_dat  in  DAT_WIDTH  FIFO read data.
- rd_empty  in  1  FIFO empty flag.
- mismatch  out  1  registered per-word compare failure pulse.
- any_mismatch  out  1  sticky OR of all `mismatch` pulses.
- err_cnt  out  CNT_WIDTH  count of mismatches, saturating at all-ones.
- rd_cntr  out  CNT_WIDTH  count of reads issued, wrapping.
- first_exp, first_got  out  DAT_WIDTH each  expected and actual word of the first mismatch.
- first_idx  out  CNT_WIDTH  read index (value of `rd_cntr` at issue) of the first mismatch.
- flag_err  out  1  sticky flag-consistency failure.

## Operation
- Mode inputs are registered once (`wr_mode_r`, `rd_mode_r`); pacing uses only the registered copies.
- Throttle: two free-running 8-bit LFSRs with distinct non-zero seeds (write 0x01, read 0x80). Each LFSR advances every cycle, including while its side is off.
  - allow = 1 for mode 01.
  - allow = lfsr[0] for mode 10.
  - allow = (lfsr[1:0] == 0) for mode 11.
  - allow = 0 for mode 00.
- `wr_req` = allow_w & !wr_full. `rd_req` = allow_r & !rd_empty. Both are combinational from registers and flags, so a request is never issued into full or from empty.
- Write generator: `wr_dat` = p(w), where w is the number of writes since reset; w advances on each `wr_req`.
- Check generator: an identical generator advances on each `rd_req`. Its current value plus `rd_cntr` enter a RD_LATENCY-deep valid/expected/index pipeline.
- Compare: when the pipeline output is valid, `mismatch` <= (exp != rd_dat); otherwise `mismatch` <= 0.
- On the first mismatch, capture `first_exp`, `first_got` and `first_idx`; they hold until `sclr`.
- Occupancy model `occ` (0..DEPTH):
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous read and write, or on neither.
- Flag check (FLAG_CHECK = 1): `flag_err` sets when (occ == DEPTH && !wr_full) or (occ == 0 && !rd_empty).
  - Conservative flags do not set `flag_err`: full asserted early, or empty held asserted after a write.
  - With FLAG_CHECK = 0, `flag_err` is tied to 0 and `occ` is removed.
- Reset, including mid-operation, has the following effects:
  - All outputs go to 0, `occ` to 0, and the read pipeline is emptied.
  - Both generators restart at p(0).
  - LFSRs return to their seeds.

## Timing
- All outputs are 0 while `sclr` is high and on the first cycle after it; `wr_dat` shows p(0) from the first cycle after reset.
- Mode change reaches the request outputs 1 cycle after the input change.
- A read issued at edge t has its data sampled at edge t+RD_LATENCY. For RD_LATENCY = 0, data is sampled in the same cycle as the request.
- `mismatch`, `err_cnt`, `any_mismatch` and the first-error capture all update on the edge where data is sampled, and are visible the following cycle.
- `err_cnt` saturates: at all-ones, further mismatches leave it unchanged.
- `rd_cntr` wraps modulo 2^CNT_WIDTH; `first_idx` uses the wrapped value.
- `flag_err` is registered, one cycle after the offending condition.

## Structure
- Shared package `fifo_test_pkg`: mode encodings (MODE_OFF, MODE_CONT, MODE_R50, MODE_R25), throttle seeds, and LFSR tap masks for DAT_WIDTH 8..32 plus the 8-bit throttle.
- One sub-module: `test_pattern_gen`.
  - Parameters: WIDTH, PATTERN.
  - Ports: clk, sclr, ena, val.
  - Instantiated twice, once for write and once for check.
- Throttles, pipeline, compare and occupancy model stay in the top level.

## Test plan
- Reference-model FIFO, DEPTH 32, RD_LATENCY 1, both modes 01 for 200 cycles:
  - 0 on `err_cnt`, `any_mismatch` and `flag_err`.
  - `rd_cntr` equals the number of reads issued; the first word read is 0x0000.
- Write 01, read 00 until full: exactly 32 writes, `wr_req` low while `wr_full` is high. Then read 01, write 00: 32 reads returning 0x0000..0x001F, then `rd_req` stays low.
- Both sides in mode 11 for 5000 cycles, RD_LATENCY set to 0, 1 and 3 in turn: no mismatch in any run.
- Corrupt the model's data on read index 5 by XOR 0x0001:
  - `mismatch` pulses once; `err_cnt` = 1.
  - `first_idx` = 5, `first_exp` = 0x0005, `first_got` = 0x0004.
  - `any_mismatch` stays 1 until reset.
- Model deasserts `wr_full` at 32 words: `flag_err` = 1 one cycle later. Separately, with FLAG_CHECK = 0, `flag_err` stays 0.
- Assert `sclr` mid-transfer with 10 words buffered:
  - All outputs go to 0 and `wr_dat` shows 0x0000 after release.
  - Traffic resumes with no mismatches.
- Force 70000 mismatches with CNT_WIDTH 16: `err_cnt` holds at 0xFFFF.

Source files
------------

// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO stress harness: pacing modes, throttle
// seeds and maximal-length LFSR tap masks.
package fifo_test_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_CONT = 2'b01,
    MODE_R50  = 2'b10,
    MODE_R25  = 2'b11
  } mode_e;

  localparam logic [7:0] WR_THR_SEED = 8'h01;
  localparam logic [7:0] RD_THR_SEED = 8'h80;
  localparam logic [7:0] THR_TAPS    = 8'hB8;

  // Left-shifting Fibonacci taps; bit k set means stage k+1 feeds back.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  function automatic logic [7:0] thr_next(input logic [7:0] s);
    return {s[6:0], ^(s & THR_TAPS)};
  endfunction

  function automatic logic mode_allow(input mode_e m, input logic [7:0] s);
    case (m)
      MODE_CONT: return 1'b1;
      MODE_R50:  return s[0];
      MODE_R25:  return (s[1:0] == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_stress_test_if.sv
// Req/flag handshake between the stress harness (master) and the FIFO under test (slave).
interface fifo_stress_test_if #(
  parameter int DAT_WIDTH = 16
);
  logic [DAT_WIDTH-1:0] wr_dat;
  logic                 wr_req;
  logic                 wr_full;
  logic                 rd_req;
  logic [DAT_WIDTH-1:0] rd_dat;
  logic                 rd_empty;

  modport master (output wr_dat, wr_req, rd_req, input wr_full, rd_dat, rd_empty);
  modport slave  (input wr_dat, wr_req, rd_req, output wr_full, rd_dat, rd_empty);
endinterface

// File: rtl/test_pattern_gen.sv
// Deterministic word generator: counter or maximal-length LFSR, one step per ena.
module test_pattern_gen
  import fifo_test_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PATTERN = 0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             ena,
  output logic [WIDTH-1:0] val
);
  localparam logic [WIDTH-1:0] SEED = (PATTERN == 1) ? WIDTH'(1) : '0;
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] val_q, val_d;

  // NOTE: val_d defaults to val_q before any condition, so no path through this block can infer a latch.
  always_comb begin
    val_d = val_q;
    if (ena) begin
      if (PATTERN == 1) val_d = {val_q[WIDTH-2:0], ^(val_q & TAPS)};
      else              val_d = val_q + WIDTH'(1);
    end
  end

  // NOTE: state uses <= so every flop samples pre-edge values independent of statement order.
  always_ff @(posedge clk) begin
    if (sclr) val_q <= SEED;
    else      val_q <= val_d;
  end

  assign val = val_q;

endmodule

// File: rtl/fifo_stress_test.sv
// FIFO stress harness: paced pattern writer, latency-aware read checker,
// error capture and optional full/empty flag cross-check.
module fifo_stress_test
  import fifo_test_pkg::*;
#(
  parameter int DAT_WIDTH  = 16,
  parameter int DEPTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int PATTERN    = 0,
  parameter int CNT_WIDTH  = 16,
  parameter int FLAG_CHECK = 1
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic [1:0]           wr_mode,
  input  logic [1:0]           rd_mode,
  fifo_stress_test_if.master   fif,
  output logic                 mismatch,
  output logic                 any_mismatch,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] rd_cntr,
  output logic [DAT_WIDTH-1:0] first_exp,
  output logic [DAT_WIDTH-1:0] first_got,
  output logic [CNT_WIDTH-1:0] first_idx,
  output logic                 flag_err
);
  typedef struct packed {
    logic                 vld;
    logic [DAT_WIDTH-1:0] exp;
    logic [CNT_WIDTH-1:0] idx;
  } rd_tag_t;

  mode_e                wr_mode_q, wr_mode_d, rd_mode_q, rd_mode_d;
  logic [7:0]           wr_thr_q, wr_thr_d, rd_thr_q, rd_thr_d;
  logic                 wr_req, rd_req;
  logic [DAT_WIDTH-1:0] wr_val, chk_val;
  rd_tag_t              issue, cmp;
  logic                 mismatch_q, mismatch_d, any_q, any_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, rd_cntr_q, rd_cntr_d, first_idx_q, first_idx_d;
  logic [DAT_WIDTH-1:0] first_exp_q, first_exp_d, first_got_q, first_got_d;

  always_comb begin
    wr_mode_d = mode_e'(wr_mode);
    rd_mode_d = mode_e'(rd_mode);
    wr_thr_d  = thr_next(wr_thr_q);
    rd_thr_d  = thr_next(rd_thr_q);
  end

  assign wr_req     = mode_allow(wr_mode_q, wr_thr_q) & ~fif.wr_full;
  assign rd_req     = mode_allow(rd_mode_q, rd_thr_q) & ~fif.rd_empty;
  assign fif.wr_req = wr_req;
  assign fif.rd_req = rd_req;
  assign fif.wr_dat = wr_val;

  test_pattern_gen #(.WIDTH(DAT_WIDTH), .PATTERN(PATTERN)) u_wr_gen (
    .clk(clk), .sclr(sclr), .ena(wr_req), .val(wr_val)
  );

  test_pattern_gen #(.WIDTH(DAT_WIDTH), .PATTERN(PATTERN)) u_chk_gen (
    .clk(clk), .sclr(sclr), .ena(rd_req), .val(chk_val)
  );

  assign issue = '{vld: rd_req, exp: chk_val, idx: rd_cntr_q};

  if (RD_LATENCY == 0) begin : g_showahead
    assign cmp = issue;
  end else begin : g_pipe
    rd_tag_t pipe_q [RD_LATENCY];
    rd_tag_t pipe_d [RD_LATENCY];

    always_comb begin
      pipe_d[0] = issue;
      for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    // NOTE: these stages are plain flops rather than RAM, so they are cleared on reset; a surviving valid bit would compare against a flushed FIFO.
    always_ff @(posedge clk) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        if (sclr) pipe_q[i] <= '0;
        else      pipe_q[i] <= pipe_d[i];
      end
    end

    assign cmp = pipe_q[RD_LATENCY-1];
  end

  always_comb begin
    mismatch_d  = cmp.vld && (cmp.exp != fif.rd_dat);
    any_d       = any_q | mismatch_d;
    err_cnt_d   = err_cnt_q;
    if (mismatch_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    first_idx_d = first_idx_q;
    if (mismatch_d && !any_q) begin
      first_exp_d = cmp.exp;
      first_got_d = fif.rd_dat;
      first_idx_d = cmp.idx;
    end
    rd_cntr_d   = rd_cntr_q + CNT_WIDTH'(rd_req);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_mode_q   <= MODE_OFF;
      rd_mode_q   <= MODE_OFF;
      wr_thr_q    <= WR_THR_SEED;
      rd_thr_q    <= RD_THR_SEED;
      mismatch_q  <= 1'b0;
      any_q       <= 1'b0;
      err_cnt_q   <= '0;
      rd_cntr_q   <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      first_idx_q <= '0;
    end else begin
      wr_mode_q   <= wr_mode_d;
      rd_mode_q   <= rd_mode_d;
      wr_thr_q    <= wr_thr_d;
      rd_thr_q    <= rd_thr_d;
      mismatch_q  <= mismatch_d;
      any_q       <= any_d;
      err_cnt_q   <= err_cnt_d;
      rd_cntr_q   <= rd_cntr_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign any_mismatch = any_q;
  assign err_cnt      = err_cnt_q;
  assign rd_cntr      = rd_cntr_q;
  assign first_exp    = first_exp_q;
  assign first_got    = first_got_q;
  assign first_idx    = first_idx_q;

  // Flags may be conservative; only a full/empty claim the occupancy model contradicts is an error.
  if (FLAG_CHECK != 0) begin : g_flag
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             flag_err_q, flag_err_d;

    always_comb begin
      occ_d = occ_q;
      if (wr_req && !rd_req && (occ_q != OCC_MAX))   occ_d = occ_q + OCC_W'(1);
      else if (rd_req && !wr_req && (occ_q != '0))   occ_d = occ_q - OCC_W'(1);
      flag_err_d = flag_err_q
                 | ((occ_q == OCC_MAX) && !fif.wr_full)
                 | ((occ_q == '0) && !fif.rd_empty);
    end

    always_ff @(posedge clk) begin
      if (sclr) begin
        occ_q      <= '0;
        flag_err_q <= 1'b0;
      end else begin
        occ_q      <= occ_d;
        flag_err_q <= flag_err_d;
      end
    end

    assign flag_err = flag_err_q;
  end else begin : g_no_flag
    assign flag_err = 1'b0;
  end

endmodule
